maroc_scan_mux: RTL

- Parametrised successor to the fixed 24-bit 16:1 registered channel mux in the MAROC data collector.
- Two modes:
  - Direct-select registered mux: same function as the fixed mux, any width and channel count.
  - Scan mode: on a start pulse, atomically snapshots all channels, then streams them out in order over a valid/ready handshake with channel tags.
- Sits between the per-channel MAROC counters/ADC words and the packet builder.

---
 rtl/maroc_scan_mux.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/maroc_scan_mux.sv
// rtl/maroc_scan_mux.sv - registered channel mux with atomic snapshot scan-out
//
// Purpose: direct-select registered N_CH:1 mux that can also, on a start
// pulse, freeze all channels into a snapshot and stream them out in order
// over a valid/ready handshake with channel tags.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   din         flat channel bus, channel k at din[k*DATA_W +: DATA_W]
//   sel         direct-mode channel select
//   start       one-cycle scan request
//   dout        registered output word
//   dout_ch     channel index of dout
//   dout_valid  scan word valid
//   dout_ready  downstream accepts word when valid & ready
//   dout_last   marks the word of channel N_CH-1 during a scan
//   busy        high while scanning
//   start_drop  sticky flag: a start arrived while busy
module maroc_scan_mux #(
    parameter int DATA_W = 24,
    parameter int N_CH   = 16,
    parameter int SEL_W  = $clog2(N_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH*DATA_W-1:0]   din,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     start,
    output logic [DATA_W-1:0]        dout,
    output logic [SEL_W-1:0]         dout_ch,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic                     dout_last,
    output logic                     busy,
    output logic                     start_drop
);

    typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

    state_t                   state_q, state_d;
    logic [DATA_W-1:0]        dout_q, dout_d;
    logic [SEL_W-1:0]         dout_ch_q, dout_ch_d;
    logic                     dout_valid_q, dout_valid_d;
    logic                     dout_last_q, dout_last_d;
    logic                     start_drop_q, start_drop_d;
    logic [N_CH*DATA_W-1:0]   snap_q, snap_d;

    logic [DATA_W-1:0]        direct_word;
    logic [SEL_W-1:0]         next_idx;
    logic                     at_last;

    // Selects one word from a flat bus; indices past N_CH-1 (possible when
    // N_CH is not a power of two) yield zero.
    function automatic logic [DATA_W-1:0] pick_word(
        input logic [N_CH*DATA_W-1:0] bus,
        input logic [SEL_W-1:0]       idx
    );
        logic [DATA_W-1:0] w;
        w = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (idx == SEL_W'(k)) begin
                w = bus[k*DATA_W +: DATA_W];
            end
        end
        return w;
    endfunction

    // The scan index is dout_ch itself, so no separate counter is kept.
    assign direct_word = pick_word(din, sel);
    assign next_idx    = dout_ch_q + SEL_W'(1);
    assign at_last     = (dout_ch_q == LAST_CH);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SCAN;
            SCAN:    if (dout_ready && at_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        dout_d       = dout_q;
        dout_ch_d    = dout_ch_q;
        dout_valid_d = dout_valid_q;
        dout_last_d  = dout_last_q;
        start_drop_d = start_drop_q;
        snap_d       = snap_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    snap_d       = din;
                    dout_d       = din[DATA_W-1:0];
                    dout_ch_d    = '0;
                    dout_valid_d = 1'b1;
                    dout_last_d  = (N_CH == 1) ? 1'b1 : 1'b0;
                end else begin
                    dout_d       = direct_word;
                    dout_ch_d    = sel;
                    dout_valid_d = 1'b0;
                    dout_last_d  = 1'b0;
                end
            end
            SCAN: begin
                if (start) begin
                    start_drop_d = 1'b1;
                end
                if (dout_ready) begin
                    if (at_last) begin
                        // Final word accepted: fall straight back into direct mode.
                        dout_d       = direct_word;
                        dout_ch_d    = sel;
                        dout_valid_d = 1'b0;
                        dout_last_d  = 1'b0;
                    end else begin
                        dout_d       = pick_word(snap_q, next_idx);
                        dout_ch_d    = next_idx;
                        dout_last_d  = (next_idx == LAST_CH);
                    end
                end
            end
            default: begin
                dout_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q       <= '0;
            dout_ch_q    <= '0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
            start_drop_q <= 1'b0;
        end else begin
            dout_q       <= dout_d;
            dout_ch_q    <= dout_ch_d;
            dout_valid_q <= dout_valid_d;
            dout_last_q  <= dout_last_d;
            start_drop_q <= start_drop_d;
        end
    end

    // Snapshot contents are meaningless outside a scan, so no reset.
    always_ff @(posedge clk) begin
        snap_q <= snap_d;
    end

    assign dout       = dout_q;
    assign dout_ch    = dout_ch_q;
    assign dout_valid = dout_valid_q;
    assign dout_last  = dout_last_q;
    assign busy       = (state_q == SCAN);
    assign start_drop = start_drop_q;

endmodule
